// File: rtl/cv32e40p_apu_resp_model_if.sv
// APU request/writeback bundle between the core (master) and an APU responder (slave).
// Request fields are sampled by the responder on the accepting edge; response fields are valid with rvalid.
interface cv32e40p_apu_resp_model_if;
  logic        req;
  logic        gnt;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] operand_c;
  logic [5:0]  waddr;
  logic        rvalid;
  logic [5:0]  rwaddr;
  logic [31:0] result;
  logic [4:0]  flags;

  modport master (
    output req, op, operand_a, operand_b, operand_c, waddr,
    input  gnt, rvalid, rwaddr, result, flags
  );

  modport slave (
    input  req, op, operand_a, operand_b, operand_c, waddr,
    output gnt, rvalid, rwaddr, result, flags
  );
endinterface

// File: rtl/cv32e40p_apu_resp_model.sv
// Fixed-latency APU responder: accepts integer ops from the core and returns result/flags/waddr
// in order, LATENCY cycles after the accept, with at most MAX_OUTSTANDING requests in flight.
module cv32e40p_apu_resp_model #(
  parameter int LATENCY         = 3,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  cv32e40p_apu_resp_model_if.slave    apu,
  input  logic                        gnt_stall_i,
  output logic                        busy_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  // Returns {flags[4:0], result[31:0]}; flags are {NV,DZ,OF,UF,NX}.
  function automatic logic [36:0] apu_compute(input logic [2:0]  op,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] c);
    logic [63:0] prod;
    logic [31:0] plo;
    logic [31:0] res;
    logic        of;
    logic        nx;
    prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    plo  = prod[31:0];
    res  = 32'd0;
    of   = 1'b0;
    nx   = 1'b0;
    case (op)
      3'd0: begin
        res = a + b;
        of  = (a[31] == b[31]) && (res[31] != a[31]);
      end
      3'd1: begin
        res = a - b;
        of  = (a[31] != b[31]) && (res[31] != a[31]);
      end
      3'd2: begin
        res = plo;
        nx  = |prod[63:32];
      end
      // MAC overflow only looks at the addition of c to the truncated product.
      3'd3: begin
        res = plo + c;
        of  = (plo[31] == c[31]) && (res[31] != plo[31]);
        nx  = |prod[63:32];
      end
      3'd4: res = ($signed(a) < $signed(b)) ? a : b;
      3'd5: res = ($signed(a) > $signed(b)) ? a : b;
      3'd6: res = a ^ b;
      3'd7: res = a;
      default: res = 32'd0;
    endcase
    return {1'b0, 1'b0, of, 1'b0, nx, res};
  endfunction

  logic                accept_s;
  logic [36:0]         comp_s;
  logic [3:0]          count_r;
  logic [LATENCY-1:0]  vld_r;
  logic [5:0]          waddr_r  [LATENCY];
  logic [31:0]         result_r [LATENCY];
  logic [4:0]          flags_r  [LATENCY];

  // Grant uses the registered count only, so a returning result never frees a slot in the same cycle.
  assign apu.gnt  = apu.req & ~gnt_stall_i & (count_r < MAX_CNT) & rst_n;
  assign accept_s = apu.req & apu.gnt;
  assign comp_s   = apu_compute(apu.op, apu.operand_a, apu.operand_b, apu.operand_c);

  // Result pipeline; payload only moves with a valid so the last stage holds the last returned value.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        waddr_r[i]  <= 6'd0;
        result_r[i] <= 32'd0;
        flags_r[i]  <= 5'd0;
      end
    end else begin
      vld_r[0] <= accept_s;
      if (accept_s) begin
        waddr_r[0]  <= apu.waddr;
        result_r[0] <= comp_s[31:0];
        flags_r[0]  <= comp_s[36:32];
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          waddr_r[i]  <= waddr_r[i-1];
          result_r[i] <= result_r[i-1];
          flags_r[i]  <= flags_r[i-1];
        end
      end
    end
  end

  // Outstanding-request counter: +1 per accept, -1 per returned result.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      count_r <= 4'd0;
    end else begin
      case ({accept_s, vld_r[LATENCY-1]})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign apu.rvalid = vld_r[LATENCY-1];
  assign apu.rwaddr = waddr_r[LATENCY-1];
  assign apu.result = result_r[LATENCY-1];
  assign apu.flags  = flags_r[LATENCY-1];
  assign busy_o     = (count_r != 4'd0);

endmodule

// File: tb/tb_cv32e40p_apu_resp_model.sv
// Bench for cv32e40p_apu_resp_model: two instances (MAX_OUTSTANDING 3 and 1) share one stimulus
// stream and are checked every cycle against a queue-based reference of the responder.
module tb_cv32e40p_apu_resp_model;

  localparam int LAT = 3;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  typedef struct {
    int          due;
    logic [5:0]  waddr;
    logic [31:0] result;
    logic [4:0]  flags;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [2:0]  op;
  logic [31:0] opa, opb, opc;
  logic [5:0]  waddr;
  logic        stall;
  logic        busy0, busy1;
  logic        checking = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  cv32e40p_apu_resp_model_if if0 ();
  cv32e40p_apu_resp_model_if if1 ();

  assign if0.req = req;  assign if0.op = op;  assign if0.waddr = waddr;
  assign if0.operand_a = opa;  assign if0.operand_b = opb;  assign if0.operand_c = opc;
  assign if1.req = req;  assign if1.op = op;  assign if1.waddr = waddr;
  assign if1.operand_a = opa;  assign if1.operand_b = opb;  assign if1.operand_c = opc;

  cv32e40p_apu_resp_model #(.LATENCY(LAT), .MAX_OUTSTANDING(3)) dut0 (
    .clk_i(clk), .rst_n(rst_n), .apu(if0), .gnt_stall_i(stall), .busy_o(busy0)
  );
  cv32e40p_apu_resp_model #(.LATENCY(LAT), .MAX_OUTSTANDING(1)) dut1 (
    .clk_i(clk), .rst_n(rst_n), .apu(if1), .gnt_stall_i(stall), .busy_o(busy1)
  );

  always #5 clk = ~clk;

  logic        obs_gnt [2];
  logic        obs_rv  [2];
  logic        obs_bsy [2];
  logic [5:0]  obs_wa  [2];
  logic [31:0] obs_res [2];
  logic [4:0]  obs_flg [2];
  assign obs_gnt[0] = if0.gnt;    assign obs_gnt[1] = if1.gnt;
  assign obs_rv[0]  = if0.rvalid; assign obs_rv[1]  = if1.rvalid;
  assign obs_bsy[0] = busy0;      assign obs_bsy[1] = busy1;
  assign obs_wa[0]  = if0.rwaddr; assign obs_wa[1]  = if1.rwaddr;
  assign obs_res[0] = if0.result; assign obs_res[1] = if1.result;
  assign obs_flg[0] = if0.flags;  assign obs_flg[1] = if1.flags;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference arithmetic on 64-bit signed integers, then range checks for overflow.
  function automatic logic [36:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
    longint sa, sb, sc, p, s, pl;
    logic [31:0] res;
    logic of, nx;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sc = longint'($signed(c));
    p  = sa * sb;
    res = 32'd0; of = 1'b0; nx = 1'b0;
    case (o)
      3'd0: begin s = sa + sb; res = s[31:0]; of = (s > MAXI) || (s < MINI); end
      3'd1: begin s = sa - sb; res = s[31:0]; of = (s > MAXI) || (s < MINI); end
      3'd2: begin res = p[31:0]; nx = (p[63:32] != 32'd0); end
      3'd3: begin
        pl = longint'($signed(p[31:0]));
        s  = pl + sc;
        res = s[31:0];
        of = (s > MAXI) || (s < MINI);
        nx = (p[63:32] != 32'd0);
      end
      3'd4: res = (sa < sb) ? a : b;
      3'd5: res = (sa > sb) ? a : b;
      3'd6: res = a ^ b;
      default: res = a;
    endcase
    return {1'b0, 1'b0, of, 1'b0, nx, res};
  endfunction

  resp_t       q [2][$];
  logic [5:0]  last_wa  [2] = '{6'd0, 6'd0};
  logic [31:0] last_res [2] = '{32'd0, 32'd0};
  logic [4:0]  last_flg [2] = '{5'd0, 5'd0};

  // Per-cycle reference: outstanding list per instance, compared on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        int    maxo;
        logic  exp_gnt, exp_rv;
        resp_t e;
        logic [36:0] r;
        maxo    = (d == 0) ? 3 : 1;
        exp_gnt = req && !stall && rst_n && (q[d].size() < maxo);
        exp_rv  = (q[d].size() != 0) && (q[d][0].due == cyc);
        if (exp_rv) begin
          last_wa[d]  = q[d][0].waddr;
          last_res[d] = q[d][0].result;
          last_flg[d] = q[d][0].flags;
        end
        check($sformatf("gnt%0d", d),    64'(obs_gnt[d]), 64'(exp_gnt));
        check($sformatf("rvalid%0d", d), 64'(obs_rv[d]),  64'(exp_rv));
        check($sformatf("busy%0d", d),   64'(obs_bsy[d]), 64'(q[d].size() != 0));
        check($sformatf("waddr%0d", d),  64'(obs_wa[d]),  64'(last_wa[d]));
        check($sformatf("result%0d", d), 64'(obs_res[d]), 64'(last_res[d]));
        check($sformatf("flags%0d", d),  64'(obs_flg[d]), 64'(last_flg[d]));
        if (exp_rv) void'(q[d].pop_front());
        if (req && exp_gnt) begin
          r = ref_op(op, opa, opb, opc);
          e.due = cyc + LAT; e.waddr = waddr; e.result = r[31:0]; e.flags = r[36:32];
          q[d].push_back(e);
        end
        if (!rst_n) begin
          q[d].delete();
          last_wa[d] = 6'd0; last_res[d] = 32'd0; last_flg[d] = 5'd0;
        end
      end
      cyc++;
    end
  end

  task automatic step(input logic r, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [5:0] w, input logic s, input logic rn);
    @(posedge clk);
    #1;
    req = r; op = o; opa = a; opb = b; opc = c; waddr = w; stall = s; rst_n = rn;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] edge_vals [6];
    edge_vals = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00010000, 32'd0, 32'd1};
    if ($urandom_range(0, 2) == 0) return edge_vals[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    rst_n = 1'b0; req = 1'b0; op = 3'd0; opa = 32'd0; opb = 32'd0; opc = 32'd0;
    waddr = 6'd0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checking = 1'b1;
    idle(2);
    // Single ADD, then overflow cases
    step(1'b1, 3'd0, 32'd5, 32'd7, 32'd0, 6'h0A, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 3'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 6'h11, 1'b0, 1'b1);
    idle(1);
    step(1'b1, 3'd2, 32'h00010000, 32'h00010000, 32'd0, 6'h12, 1'b0, 1'b1);
    idle(5);
    // Back-to-back, then req held so both instances hit their outstanding limits
    step(1'b1, 3'd6, 32'h0F0F0F0F, 32'h00FF00FF, 32'd0, 6'h01, 1'b0, 1'b1);
    step(1'b1, 3'd4, 32'hFFFFFFFE, 32'd3, 32'd0, 6'h21, 1'b0, 1'b1);
    step(1'b1, 3'd3, 32'd6, 32'd7, 32'h7FFFFFD6, 6'h03, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 3'd1, 32'h80000000, 32'd1, 32'd0, 6'(i), 1'b0, 1'b1);
    idle(6);
    // Stall with request held
    for (int i = 0; i < 5; i++) step(1'b1, 3'd5, 32'd9, 32'hFFFFFFF0, 32'd0, 6'h2A, 1'b1, 1'b1);
    step(1'b1, 3'd5, 32'd9, 32'hFFFFFFF0, 32'd0, 6'h2A, 1'b0, 1'b1);
    idle(6);
    // Reset with two ops in flight
    step(1'b1, 3'd7, 32'hDEADBEEF, 32'd0, 32'd0, 6'h05, 1'b0, 1'b1);
    step(1'b1, 3'd0, 32'd1, 32'd2, 32'd0, 6'h06, 1'b0, 1'b1);
    step(1'b1, 3'd0, 32'd3, 32'd4, 32'd0, 6'h07, 1'b0, 1'b0);
    idle(6);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), pick(), pick(), pick(),
           6'($urandom_range(0, 63)), $urandom_range(0, 4) == 0, $urandom_range(0, 99) != 0);
    end
    idle(8);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
